// File: rtl/segment_pkg.sv
// rtl/segment_pkg.sv - shared types and constants for the segment register bank
// Contents: seg_t segment encodings, inhibit_state_t FSM states, CS reset constant.
package segment_pkg;

  typedef enum logic [1:0] {
    ES = 2'd0,
    CS = 2'd1,
    SS = 2'd2,
    DS = 2'd3
  } seg_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    SHADOW = 2'd2
  } inhibit_state_t;

  localparam logic [15:0] CS_RESET_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/segment_register_bank_if.sv
// rtl/segment_register_bank_if.sv - sequencer-facing signal bundle of the segment register bank
// master: drives rd_sel, wr_en/wr_sel/wr_val, override_set/override_sel, default_sel, instr_done
//         and observes rd_val, cs, eff_sel, int_inhibit.
// slave:  the register bank, with the opposite directions.
interface segment_register_bank_if #(
  parameter int WIDTH        = 16,
  parameter int NUM_SEGS     = 4,
  parameter int NUM_RD_PORTS = 2
);
  localparam int SEL_W = $clog2(NUM_SEGS);

  logic [NUM_RD_PORTS-1:0][SEL_W-1:0] rd_sel;
  logic [NUM_RD_PORTS-1:0][WIDTH-1:0] rd_val;
  logic                               wr_en;
  logic [SEL_W-1:0]                   wr_sel;
  logic [WIDTH-1:0]                   wr_val;
  logic [WIDTH-1:0]                   cs;
  logic                               override_set;
  logic [SEL_W-1:0]                   override_sel;
  logic [SEL_W-1:0]                   default_sel;
  logic [SEL_W-1:0]                   eff_sel;
  logic                               instr_done;
  logic                               int_inhibit;

  modport master (
    output rd_sel, wr_en, wr_sel, wr_val, override_set, override_sel, default_sel, instr_done,
    input  rd_val, cs, eff_sel, int_inhibit
  );

  modport slave (
    input  rd_sel, wr_en, wr_sel, wr_val, override_set, override_sel, default_sel, instr_done,
    output rd_val, cs, eff_sel, int_inhibit
  );
endinterface

// File: rtl/segment_inhibit_fsm.sv
// rtl/segment_inhibit_fsm.sv - interrupt-inhibit shadow after an SS write
// Ports: clk, reset (sync, active-high), ss_wr (SS written this cycle),
//        instr_done (last cycle of an instruction), int_inhibit (registered state decode).
module segment_inhibit_fsm
  import segment_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ss_wr,
  input  logic instr_done,
  output logic int_inhibit
);

  inhibit_state_t state, state_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ARMED: the SS-writing instruction is still executing.
  // SHADOW: the instruction after it is executing; a fresh SS write there
  // restarts the shadow so back-to-back SS loads stay protected.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ss_wr) state_next = instr_done ? SHADOW : ARMED;
      end
      ARMED: begin
        if (instr_done) state_next = SHADOW;
      end
      SHADOW: begin
        if (ss_wr)           state_next = instr_done ? SHADOW : ARMED;
        else if (instr_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign int_inhibit = (state != IDLE);

endmodule

// File: rtl/segment_register_bank.sv
// rtl/segment_register_bank.sv - segment register file with bypassed read ports, override latch and inhibit FSM
// Ports: clk, reset (sync, active-high), bus (slave modport): registered read ports rd_sel/rd_val,
//        write port wr_en/wr_sel/wr_val, cs, override prefix latch override_set/override_sel/default_sel
//        -> eff_sel, instr_done, int_inhibit.
module segment_register_bank
  import segment_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               NUM_SEGS     = 4,
  parameter int               NUM_RD_PORTS = 2,
  parameter logic [WIDTH-1:0] CS_RESET     = WIDTH'(CS_RESET_DEFAULT)
) (
  input logic                    clk,
  input logic                    reset,
  segment_register_bank_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_SEGS);

  logic [WIDTH-1:0]                   regs [NUM_SEGS];
  logic [NUM_RD_PORTS-1:0][WIDTH-1:0] rd_q;
  logic                               ovr_valid;
  logic [SEL_W-1:0]                   ovr_sel;
  logic                               ss_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SEGS; i++) begin
        regs[i] <= (i == int'(CS)) ? CS_RESET : '0;
      end
    end else if (bus.wr_en) begin
      regs[bus.wr_sel] <= bus.wr_val;
    end
  end

  // Each port bypasses the same-cycle write independently of the others.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (reset) begin
        rd_q[p] <= '0;
      end else if (bus.wr_en && (bus.wr_sel == bus.rd_sel[p])) begin
        rd_q[p] <= bus.wr_val;
      end else begin
        rd_q[p] <= regs[bus.rd_sel[p]];
      end
    end
  end

  // A prefix seen together with instr_done belongs to the next instruction,
  // so the set takes priority over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_valid <= 1'b0;
      ovr_sel   <= '0;
    end else if (bus.override_set) begin
      ovr_valid <= 1'b1;
      ovr_sel   <= bus.override_sel;
    end else if (bus.instr_done) begin
      ovr_valid <= 1'b0;
    end
  end

  assign ss_wr       = bus.wr_en && (bus.wr_sel == SEL_W'(SS));
  assign bus.rd_val  = rd_q;
  assign bus.cs      = regs[SEL_W'(CS)];
  assign bus.eff_sel = ovr_valid ? ovr_sel : bus.default_sel;

  segment_inhibit_fsm u_inhibit_fsm (
    .clk         (clk),
    .reset       (reset),
    .ss_wr       (ss_wr),
    .instr_done  (bus.instr_done),
    .int_inhibit (bus.int_inhibit)
  );

endmodule

// File: tb/tb_segment_register_bank.sv
// tb/tb_segment_register_bank.sv - directed self-checking bench for segment_register_bank
module tb_segment_register_bank;
  import segment_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  segment_register_bank_if #(.WIDTH(16), .NUM_SEGS(4), .NUM_RD_PORTS(2)) bus ();

  segment_register_bank #(
    .WIDTH(16), .NUM_SEGS(4), .NUM_RD_PORTS(2), .CS_RESET(16'hFFFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en        = 1'b0;
    bus.wr_sel       = ES;
    bus.wr_val       = 16'h0000;
    bus.override_set = 1'b0;
    bus.override_sel = ES;
    bus.instr_done   = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp_val [4];
    exp_val[0] = 16'h0000; exp_val[1] = 16'hFFFF; exp_val[2] = 16'h0000; exp_val[3] = 16'h0000;
    idle_inputs();
    bus.default_sel = DS;
    bus.rd_sel[0]   = CS;
    bus.rd_sel[1]   = CS;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if (bus.rd_val !== 32'h0) begin
      n_fail++; $display("FAIL reset_rd_val: got %h want %h", bus.rd_val, 32'h0);
    end
    n_checks++;
    if (bus.cs !== 16'hFFFF) begin
      n_fail++; $display("FAIL reset_cs: got %h want %h", bus.cs, 16'hFFFF);
    end
    n_checks++;
    if (bus.int_inhibit !== 1'b0) begin
      n_fail++; $display("FAIL reset_inhibit: got %b want 0", bus.int_inhibit);
    end
    n_checks++;
    if (bus.eff_sel !== DS) begin
      n_fail++; $display("FAIL reset_eff_sel: got %0d want %0d", bus.eff_sel, DS);
    end
    for (int s = 0; s < 4; s++) begin
      bus.rd_sel[0] = 2'(s);
      bus.rd_sel[1] = 2'(s);
      tick();
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (bus.rd_val[p] !== exp_val[s]) begin
          n_fail++; $display("FAIL reset_read seg%0d port%0d: got %h want %h", s, p, bus.rd_val[p], exp_val[s]);
        end
      end
    end
  endtask

  task automatic test_write_bypass();
    bus.rd_sel[0] = DS;
    bus.rd_sel[1] = ES;
    bus.wr_en     = 1'b1;
    bus.wr_sel    = DS;
    bus.wr_val    = 16'h1234;
    tick();
    idle_inputs();
    n_checks++;
    if (bus.rd_val[0] !== 16'h1234) begin
      n_fail++; $display("FAIL bypass_port0: got %h want %h", bus.rd_val[0], 16'h1234);
    end
    n_checks++;
    if (bus.rd_val[1] !== 16'h0000) begin
      n_fail++; $display("FAIL bypass_port1: got %h want %h", bus.rd_val[1], 16'h0000);
    end
    tick();
    n_checks++;
    if (bus.rd_val[0] !== 16'h1234) begin
      n_fail++; $display("FAIL stored_ds: got %h want %h", bus.rd_val[0], 16'h1234);
    end
    bus.wr_en  = 1'b1;
    bus.wr_sel = CS;
    bus.wr_val = 16'h2000;
    #1;
    n_checks++;
    if (bus.cs !== 16'hFFFF) begin
      n_fail++; $display("FAIL cs_before_edge: got %h want %h", bus.cs, 16'hFFFF);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (bus.cs !== 16'h2000) begin
      n_fail++; $display("FAIL cs_write: got %h want %h", bus.cs, 16'h2000);
    end
  endtask

  task automatic test_override();
    bus.default_sel = DS;
    bus.override_set = 1'b1;
    bus.override_sel = ES;
    tick();
    idle_inputs();
    n_checks++;
    if (bus.eff_sel !== ES) begin
      n_fail++; $display("FAIL ovr_active: got %0d want %0d", bus.eff_sel, ES);
    end
    tick();
    n_checks++;
    if (bus.eff_sel !== ES) begin
      n_fail++; $display("FAIL ovr_held: got %0d want %0d", bus.eff_sel, ES);
    end
    bus.instr_done = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (bus.eff_sel !== DS) begin
      n_fail++; $display("FAIL ovr_cleared: got %0d want %0d", bus.eff_sel, DS);
    end
    bus.override_set = 1'b1;
    bus.override_sel = SS;
    bus.instr_done   = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (bus.eff_sel !== SS) begin
      n_fail++; $display("FAIL ovr_set_wins: got %0d want %0d", bus.eff_sel, SS);
    end
    bus.instr_done = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (bus.eff_sel !== DS) begin
      n_fail++; $display("FAIL ovr_cleared2: got %0d want %0d", bus.eff_sel, DS);
    end
  endtask

  task automatic test_inhibit();
    bus.wr_en  = 1'b1;
    bus.wr_sel = SS;
    bus.wr_val = 16'h0800;
    tick();
    idle_inputs();
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if (bus.int_inhibit !== 1'b1) begin
        n_fail++; $display("FAIL inhibit_cycle%0d: got %b want 1", c, bus.int_inhibit);
      end
      bus.instr_done = (c == 3) || (c == 8);
      tick();
      idle_inputs();
    end
    n_checks++;
    if (bus.int_inhibit !== 1'b0) begin
      n_fail++; $display("FAIL inhibit_fall: got %b want 0", bus.int_inhibit);
    end
  endtask

  task automatic test_back_to_back();
    bus.wr_en  = 1'b1;
    bus.wr_sel = SS;
    bus.wr_val = 16'h0900;
    tick();
    idle_inputs();
    bus.instr_done = 1'b1;
    tick();
    idle_inputs();
    bus.wr_en      = 1'b1;
    bus.wr_sel     = SS;
    bus.wr_val     = 16'h0A00;
    bus.instr_done = 1'b1;
    tick();
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (bus.int_inhibit !== 1'b1) begin
        n_fail++; $display("FAIL b2b_shadow%0d: got %b want 1", c, bus.int_inhibit);
      end
      tick();
    end
    bus.instr_done = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (bus.int_inhibit !== 1'b0) begin
      n_fail++; $display("FAIL b2b_fall: got %b want 0", bus.int_inhibit);
    end
  endtask

  task automatic test_reset_mid();
    bus.default_sel = DS;
    bus.rd_sel[0]   = SS;
    bus.wr_en       = 1'b1;
    bus.wr_sel      = SS;
    bus.wr_val      = 16'h0B00;
    bus.override_set = 1'b1;
    bus.override_sel = ES;
    tick();
    idle_inputs();
    n_checks++;
    if (bus.int_inhibit !== 1'b1 || bus.eff_sel !== ES) begin
      n_fail++; $display("FAIL pre_reset_state: got inh=%b eff=%0d want inh=1 eff=%0d", bus.int_inhibit, bus.eff_sel, ES);
    end
    reset            = 1'b1;
    bus.wr_en        = 1'b1;
    bus.wr_sel       = CS;
    bus.wr_val       = 16'h5555;
    bus.override_set = 1'b1;
    bus.override_sel = SS;
    bus.instr_done   = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    n_checks++;
    if (bus.int_inhibit !== 1'b0) begin
      n_fail++; $display("FAIL midreset_inhibit: got %b want 0", bus.int_inhibit);
    end
    n_checks++;
    if (bus.eff_sel !== DS) begin
      n_fail++; $display("FAIL midreset_eff_sel: got %0d want %0d", bus.eff_sel, DS);
    end
    n_checks++;
    if (bus.cs !== 16'hFFFF) begin
      n_fail++; $display("FAIL midreset_cs: got %h want %h", bus.cs, 16'hFFFF);
    end
    n_checks++;
    if (bus.rd_val[0] !== 16'h0000) begin
      n_fail++; $display("FAIL midreset_rd_val: got %h want %h", bus.rd_val[0], 16'h0000);
    end
    tick();
    n_checks++;
    if (bus.rd_val[0] !== 16'h0000) begin
      n_fail++; $display("FAIL midreset_ss_cleared: got %h want %h", bus.rd_val[0], 16'h0000);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.rd_sel      = '0;
    bus.default_sel = DS;
    idle_inputs();
    test_reset();
    test_write_bypass();
    test_override();
    test_inhibit();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
